// File: rtl/div_arbiter.sv
// Round-robin arbiter/sequencer sharing one restoring divider between N_REQ requesters.
// Optional WAIT watchdog enabled by defining DIV_ARB_TIMEOUT_EN.
module div_arbiter #(
    parameter int N_REQ   = 2,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*WIDTH-1:0]       req_x,
    input  logic [N_REQ*WIDTH-1:0]       req_y,
    output logic [N_REQ-1:0]             req_ready,
    output logic [N_REQ-1:0]             resp_valid,
    input  logic [N_REQ-1:0]             resp_ready,
    output logic [WIDTH-1:0]             resp_q,
    output logic [WIDTH-1:0]             resp_r,
    output logic                         resp_err,
    output logic                         div_go,
    output logic [WIDTH-1:0]             div_x,
    output logic [WIDTH-1:0]             div_y,
    input  logic                         div_done,
    input  logic [WIDTH-1:0]             div_q,
    input  logic [WIDTH-1:0]             div_r,
    output logic                         div_rst,
    output logic                         busy,
    output logic [$clog2(N_REQ)-1:0]     grant_id
);

    localparam int GW = $clog2(N_REQ);

    generate
        if (N_REQ < 2 || N_REQ > 4 || WIDTH < 1 || TIMEOUT < 1) begin : g_bad_cfg
            $error("div_arbiter: unsupported parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [GW-1:0]        r_rr_ptr;
    logic [GW-1:0]        r_g;
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_y;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_r;
    logic                 r_err;

    logic                 w_found;
    logic [GW-1:0]        w_pick;
    logic [GW:0]          w_sum;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_expire;
    logic                 w_handshake;
    logic [WIDTH-1:0]     w_x_arr [N_REQ];
    logic [WIDTH-1:0]     w_y_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_x_arr[gi] = req_x[gi*WIDTH +: WIDTH];
            assign w_y_arr[gi] = req_y[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // First valid requester at or above rr_ptr, wrapping back to 0.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (GW+1)'(k);
            if (w_sum >= (GW+1)'(N_REQ)) begin
                w_sum = w_sum - (GW+1)'(N_REQ);
            end
            if (!w_found && req_valid[w_sum[GW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[GW-1:0];
            end
        end
    end

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // A done arriving in the expiry cycle takes priority over the watchdog.
    assign w_expire = (r_state == S_WAIT) && !div_done && (r_cnt == CW'(TIMEOUT - 1));
`else
    assign w_expire = 1'b0;
`endif

    assign div_rst = ~rst_n | w_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        req_ready   = '0;
        resp_valid  = '0;
        div_go      = 1'b0;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && rst_n) begin
                    req_ready = N_REQ'(1) << w_pick;
                    w_accept  = 1'b1;
                    w_next    = (w_y_arr[w_pick] == '0) ? S_RESP : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                div_go = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (div_done) begin
                    w_done = 1'b1;
                    w_next = S_RESP;
                end else if (w_expire) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = N_REQ'(1) << r_g;
                if (resp_ready[r_g]) begin
                    w_handshake = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_g      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_q      <= '0;
            r_r      <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_g <= w_pick;
                r_x <= w_x_arr[w_pick];
                r_y <= w_y_arr[w_pick];
                if (w_y_arr[w_pick] == '0) begin
                    r_q   <= '0;
                    r_r   <= '0;
                    r_err <= 1'b1;
                end
            end
            if (w_done) begin
                r_q   <= div_q;
                r_r   <= div_r;
                r_err <= 1'b0;
            end else if (w_expire) begin
                r_q   <= '0;
                r_r   <= '0;
                r_err <= 1'b1;
            end
            if (w_handshake) begin
                r_rr_ptr <= (r_g == GW'(N_REQ - 1)) ? '0 : r_g + GW'(1);
            end
        end
    end

    assign div_x    = r_x;
    assign div_y    = r_y;
    assign resp_q   = r_q;
    assign resp_r   = r_r;
    assign resp_err = r_err;
    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_g;

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one 4-bit restoring integer divider between `N_REQ` requesters. It accepts one division request at a time and screens divide-by-zero itself, because the divider idles silently on a zero divisor and never raises done. It drives the divider's `go` and operands, holds them for the whole operation, and returns quotient, remainder and error to the granted requester over a valid/ready response. It sits between the requesting blocks and the divider datapath plus its control unit.

## Interface
- `N_REQ`, 2, number of requesters (2..4)
- `WIDTH`, 4, operand width; must match the divider
- `TIMEOUT`, 32, watchdog limit in cycles; used only with `DIV_ARB_TIMEOUT_EN`
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in N_REQ: request pending, one bit per requester
- `req_x` in N_REQ*WIDTH: dividends, packed, requester i at [i*WIDTH +: WIDTH]
- `req_y` in N_REQ*WIDTH: divisors, packed the same way
- `req_ready` out N_REQ: one-hot accept strobe
- `resp_valid` out N_REQ: one-hot response valid
- `resp_ready` in N_REQ: response taken
- `resp_q`, `resp_r` out WIDTH: quotient and remainder
- `resp_err` out 1: divide-by-zero or timeout
- `div_go` out 1: start pulse to the divider control unit
- `div_x`, `div_y` out WIDTH: operands to the divider
- `div_done` in 1: divider done, one-cycle pulse
- `div_q`, `div_r` in WIDTH: divider results
- `div_rst` out 1: active-high synchronous reset to the divider
- `busy` out 1: high whenever the state is not IDLE
- `grant_id` out clog2(N_REQ): index of the current owner

## Operation
- **States.** IDLE, LAUNCH, WAIT, RESP. Encoding is 2 bits, registered. Next state and outputs are combinational.
- **IDLE**
  - If any `req_valid` is set, pick the first set bit searching upward from `rr_ptr`, with wrap. Call it g.
  - Assert `req_ready[g]` for exactly this cycle.
  - Register x, y and g.
  - If y==0: set `resp_err`=1, q=r=0, and go to RESP.
  - Otherwise go to LAUNCH.
- **LAUNCH:** `div_go`=1 for one cycle, then WAIT.
- **WAIT**
  - `div_x`/`div_y` stay stable from LAUNCH until RESP is exited.
  - On `div_done`: register `div_q`/`div_r`, clear err, go to RESP.
  - `div_done` seen outside WAIT is ignored.
- **RESP**
  - `resp_valid[g]`=1, with q/r/err stable, until `resp_ready[g]`.
  - On the handshake: `rr_ptr` becomes (g+1) mod N_REQ, go to IDLE.
  - `resp_ready` bits for other requesters are ignored.
- **Operand driving:** `div_x`/`div_y` always drive the registered operands. `div_go` is never high outside LAUNCH, so the divider cannot restart on its own.
- **Fairness:** a requester that is continuously valid is granted within N_REQ grants.
- **Withdrawn requests:** a `req_valid` dropped before its grant is never served. Once accepted, a request completes regardless of later `req_valid`.
- **Reset values** (async, `rst_n` low):
  - Registers: state=IDLE, `rr_ptr`=0, g=0, operands=0, q=r=0, err=0.
  - Outputs: `req_ready`=0, `resp_valid`=0, `div_go`=0, `busy`=0.
- **Divider reset:** `div_rst`=1 while `rst_n` is low.
- **Reset mid-operation:** the transaction is dropped with no response. Requesters must reissue.

## Timing
- Request accepted in cycle A, y≠0:
  - `div_go` is high in A+1.
  - The divider's `go` is sampled at the end of A+1.
  - If `div_done` is seen in cycle D, `resp_valid` rises in D+1.
- Request accepted in cycle A, y==0: `resp_valid` rises in A+1; no `div_go` is issued.
- Back-to-back: the earliest next accept is the cycle after the response handshake.
- Arbiter overhead is therefore 3 cycles per operation, plus divider latency, plus response stall.
- `req_ready` and `div_go` are single-cycle pulses and never coincide.

## Configuration
- **Macro:** `DIV_ARB_TIMEOUT_EN`.
- **Defined:**
  - A cycle counter clears on entering WAIT and increments every WAIT cycle.
  - When it reaches `TIMEOUT` with no `div_done`:
    - `div_rst` pulses high for one cycle;
    - the response is q=r=0, err=1;
    - the state goes to RESP.
  - If `div_done` and expiry occur in the same cycle, `div_done` wins.
- **Undefined:**
  - No counter is built; WAIT waits indefinitely.
  - `div_rst` = ~`rst_n` only.

## Test plan
- Req0 with x=13, y=3 -> `div_go` one cycle after accept; response on `resp_valid[0]` with q=4, r=1, err=0.
- Req1 with x=9, y=0 -> `resp_valid[1]` one cycle after accept with err=1, q=r=0; `div_go` never asserted.
- Both requests valid continuously, 4 operations, resp_ready tied high -> grants alternate 0,1,0,1.
- `resp_ready` held low for 10 cycles -> `resp_valid` and q/r stable throughout; no new `req_ready` until the handshake.
- `rst_n` pulsed low during WAIT -> all outputs at reset values immediately, `div_rst`=1; next grant goes to requester 0.
- With `DIV_ARB_TIMEOUT_EN`, `div_done` held low -> after 32 WAIT cycles, one `div_rst` pulse and a response with err=1.
